// File: rtl/sram_ctrl_pkg.sv
//==== sram_ctrl_pkg -- shared types/constants for the SRAM port controller (rev 1.0) ====
`default_nettype none

package sram_ctrl_pkg;

  localparam int SRAM_AW = 10;
  localparam int SRAM_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RSP    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  // Naturally aligned accesses only; the illegal size encoding always errors.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic w_bad;
    case (size)
      SZ_BYTE: w_bad = 1'b0;
      SZ_HALF: w_bad = lane[0];
      SZ_WORD: w_bad = |lane;
      default: w_bad = 1'b1;
    endcase
    return w_bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_lane_merge.sv
//==== sram_lane_merge -- byte-lane mask, write merge and read alignment (rev 1.0) ====
`default_nettype none

module sram_lane_merge
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]         i_size,
  input  logic [1:0]         i_lane,
  input  logic [SRAM_DW-1:0] i_wdata,
  input  logic [SRAM_DW-1:0] i_dout,
  output logic [SRAM_DW-1:0] o_bm,
  output logic [SRAM_DW-1:0] o_merged,
  output logic [SRAM_DW-1:0] o_rdata
);

  logic [4:0]         w_shift;
  logic [SRAM_DW-1:0] w_bm;
  logic [SRAM_DW-1:0] w_wshift;
  logic [SRAM_DW-1:0] w_rshift;

  always_comb begin
    w_shift = {i_lane, 3'b000};
    case (i_size)
      SZ_BYTE: w_bm = 32'h0000_00FF << w_shift;
      SZ_HALF: w_bm = 32'h0000_FFFF << {i_lane[1], 4'b0000};
      SZ_WORD: w_bm = 32'hFFFF_FFFF;
      default: w_bm = 32'h0000_0000;
    endcase
  end

  // Write data is right-justified; move it into its lane and keep unmasked old bytes.
  always_comb begin
    w_wshift = i_wdata << w_shift;
    o_bm     = w_bm;
    o_merged = (i_dout & ~w_bm) | (w_wshift & w_bm);
  end

  always_comb begin
    w_rshift = i_dout >> w_shift;
    case (i_size)
      SZ_BYTE: o_rdata = {24'h000000, w_rshift[7:0]};
      SZ_HALF: o_rdata = {16'h0000, w_rshift[15:0]};
      SZ_WORD: o_rdata = w_rshift;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_ctrl.sv
//==== sram_port_ctrl -- CPU request port to single-port sync SRAM with sub-word RMW (rev 1.0) ====
`default_nettype none

module sram_port_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [11:0]        req_addr,
  input  logic [1:0]         req_size,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_din,
  output logic [SRAM_DW-1:0] sram_bm,
  output logic               sram_wen,
  output logic               sram_ren,
  output logic               sram_men,
  input  logic [SRAM_DW-1:0] sram_dout
);

  state_e             r_state;
  state_e             w_next;
  logic               r_we;
  logic [11:0]        r_addr;
  logic [1:0]         r_size;
  logic [31:0]        r_wdata;
  logic               r_err;
  logic               w_accept;
  logic               w_bad;
  logic [SRAM_DW-1:0] w_bm;
  logic [SRAM_DW-1:0] w_merged;
  logic [SRAM_DW-1:0] w_rdata;

  assign req_ready = (r_state == ST_IDLE) & rst_n;
  assign w_accept  = req_valid & req_ready;
  assign w_bad     = is_misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_wdata <= req_wdata;
      r_err   <= w_bad;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad)                w_next = ST_RSP;
          else if (!req_we)         w_next = ST_RD;
          else if (req_size == SZ_WORD) w_next = ST_WR;
          else                      w_next = ST_RMW_RD;
        end
      end
      ST_RD:     w_next = ST_RSP;
      ST_WR:     w_next = ST_RSP;
      ST_RMW_RD: w_next = ST_RMW_WR;
      ST_RMW_WR: w_next = ST_RSP;
      ST_RSP:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  sram_lane_merge u_lane_merge (
    .i_size   (r_size),
    .i_lane   (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_dout   (sram_dout),
    .o_bm     (w_bm),
    .o_merged (w_merged),
    .o_rdata  (w_rdata)
  );

  // Strobes depend on state alone, so an async reset drops them immediately.
  always_comb begin
    sram_ren = (r_state == ST_RD) || (r_state == ST_RMW_RD);
    sram_wen = (r_state == ST_WR) || (r_state == ST_RMW_WR);
    sram_men = sram_ren | sram_wen;
    sram_addr = sram_men ? r_addr[11:2] : '0;
    sram_bm   = sram_men ? w_bm : '0;
    case (r_state)
      ST_WR:     sram_din = r_wdata;
      ST_RMW_WR: sram_din = w_merged;
      default:   sram_din = '0;
    endcase
  end

  // sram_dout in RSP still holds the word fetched during RD.
  always_comb begin
    rsp_valid = (r_state == ST_RSP);
    rsp_err   = rsp_valid & r_err;
    rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_rdata : 32'h0000_0000;
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
//==== tb_sram_port_ctrl -- directed + random bench with byte-level memory reference (rev 1.0) ====
`default_nettype none

module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [11:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_bm, sram_dout;
  logic        sram_wen, sram_ren, sram_men;

  always #5 clk = ~clk;

  sram_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
    .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_men(sram_men),
    .sram_dout(sram_dout)
  );

  // Synchronous single-port SRAM with per-bit write mask.
  logic [31:0] sram_mem [0:1023];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) sram_mem[ld_addr] <= ld_data;
    else if (sram_men) begin
      if (sram_ren) sram_dout <= sram_mem[sram_addr];
      if (sram_wen) sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
    end
  end

  int          ren_cnt = 0, wen_cnt = 0, rsp_cnt = 0;
  logic [9:0]  ren_addr, wen_addr;
  logic [31:0] wen_din, wen_bm;
  always @(negedge clk) begin
    if (sram_ren) begin ren_cnt <= ren_cnt + 1; ren_addr <= sram_addr; end
    if (sram_wen) begin wen_cnt <= wen_cnt + 1; wen_addr <= sram_addr; wen_din <= sram_din; wen_bm <= sram_bm; end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // Reference: plain byte array view of the first 256 bytes.
  logic [7:0] ref_mem [0:255];

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [11:0] a);
    int n = 1 << sz;
    return (sz == 2'd3) || ((int'(a) % n) != 0);
  endfunction

  function automatic logic [31:0] model_word(input int wi);
    return {ref_mem[wi*4+3], ref_mem[wi*4+2], ref_mem[wi*4+1], ref_mem[wi*4]};
  endfunction

  task automatic do_req(input logic we, input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd,
                        input string tag, output int lat, output logic [31:0] rd, output logic er,
                        output logic one_cycle);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; break; end
    end
    @(negedge clk);
    one_cycle = !rsp_valid;
  endtask

  task automatic verify_txn(input logic we, input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd,
                            input string tag, output logic [31:0] rd);
    bit          e_err = model_err(sz, a);
    int          n = 1 << sz;
    int          wi = int'(a[7:2]);
    logic [31:0] e_rd = 32'h0, e_bm = 32'h0, e_word;
    int          e_lat, e_ren, e_wen, ren0, wen0, lat;
    logic        er, oc;
    if (!e_err && !we)
      for (int i = 0; i < n; i++) e_rd[8*i +: 8] = ref_mem[int'(a) + i];
    if (!e_err && we) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[int'(a) + i] = wd[8*i +: 8];
        e_bm[8*((int'(a) + i) % 4) +: 8] = 8'hFF;
      end
    end
    e_word = model_word(wi);
    e_lat  = e_err ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
    e_ren  = (!e_err && (!we || sz != 2'd2)) ? 1 : 0;
    e_wen  = (!e_err && we) ? 1 : 0;
    ren0 = ren_cnt; wen0 = wen_cnt;
    do_req(we, a, sz, wd, tag, lat, rd, er, oc);
    check({tag, ".lat"},   32'(lat), 32'(e_lat));
    check({tag, ".err"},   32'(er), 32'(e_err));
    check({tag, ".rdata"}, rd, e_rd);
    check({tag, ".pulse"}, 32'(oc), 32'd1);
    check({tag, ".nren"},  32'(ren_cnt - ren0), 32'(e_ren));
    check({tag, ".nwen"},  32'(wen_cnt - wen0), 32'(e_wen));
    if (e_ren == 1) check({tag, ".raddr"}, 32'(ren_addr), 32'(a[11:2]));
    if (e_wen == 1) begin
      check({tag, ".waddr"}, 32'(wen_addr), 32'(a[11:2]));
      check({tag, ".wdin"},  wen_din, e_word);
      check({tag, ".wbm"},   wen_bm, e_bm);
    end
    check({tag, ".mem"}, sram_mem[wi], e_word);
  endtask

  initial begin
    logic [31:0] rd;
    int          wen0, rsp0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 10'(i);
      ld_data = (i == 16) ? 32'hDDCC_BBAA : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = ld_data[8*b +: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;

    check("rst.ready",   32'(req_ready), 32'd0);
    check("rst.rspv",    32'(rsp_valid), 32'd0);
    check("rst.err",     32'(rsp_err), 32'd0);
    check("rst.rdata",   rsp_rdata, 32'd0);
    check("rst.strobes", 32'({sram_wen, sram_ren, sram_men}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.ready", 32'(req_ready), 32'd1);

    verify_txn(1'b0, 12'h040, 2'd2, 32'h0, "rd_w040", rd);
    check("rd_w040.const", rd, 32'hDDCC_BBAA);
    verify_txn(1'b0, 12'h043, 2'd0, 32'h0, "rd_b043", rd);
    check("rd_b043.const", rd, 32'h0000_00DD);
    verify_txn(1'b0, 12'h042, 2'd1, 32'h0, "rd_h042", rd);
    check("rd_h042.const", rd, 32'h0000_DDCC);
    verify_txn(1'b1, 12'h041, 2'd0, 32'h55, "wr_b041", rd);
    check("wr_b041.din", wen_din, 32'hDDCC_55AA);
    check("wr_b041.bm",  wen_bm, 32'h0000_FF00);
    verify_txn(1'b0, 12'h040, 2'd2, 32'h0, "rb_w040", rd);
    check("rb_w040.const", rd, 32'hDDCC_55AA);
    verify_txn(1'b1, 12'h044, 2'd2, 32'h1234_5678, "wr_w044", rd);
    check("wr_w044.bm", wen_bm, 32'hFFFF_FFFF);
    verify_txn(1'b0, 12'h042, 2'd2, 32'h0, "err_w042", rd);
    verify_txn(1'b1, 12'h002, 2'd1, 32'hBEEF, "wr_h002", rd);
    verify_txn(1'b1, 12'h010, 2'd3, 32'hFFFF_FFFF, "ill_sz3", rd);

    // Reset during RMW_RD must kill the write and the response.
    wen0 = wen_cnt; rsp0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040; req_size = 2'd0; req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rst.in_rd", 32'(sram_ren), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst.ready",   32'(req_ready), 32'd0);
    check("rmw_rst.rspv",    32'(rsp_valid), 32'd0);
    check("rmw_rst.strobes", 32'({sram_wen, sram_ren, sram_men}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmw_rst.ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rmw_rst.nwen", 32'(wen_cnt - wen0), 32'd0);
    check("rmw_rst.nrsp", 32'(rsp_cnt - rsp0), 32'd0);
    check("rmw_rst.mem",  sram_mem[16], 32'hDDCC_55AA);

    for (int t = 0; t < 150; t++) begin
      verify_txn(1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 $urandom, $sformatf("rnd%0d", t), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
